inst_decode_pipe: RTL and testbench

- Next-generation decode stage between instruction fetch and execute.
- Buffers fetched instructions in a DEPTH-entry FIFO, holds each one in a decode slot for a parametrised LATENCY, then presents the split instruction fields plus pc/pc1/distinct.
- Replaces the fixed 3-state capture/hold sequencer with a valid/ready handshake on both sides, backpressure and flush.
- Control decode (opcode/funct to control signals) stays in the existing combinational operator block, fed from this block's opcode/funct outputs.

---
 rtl/inst_decode_pipe.sv | 179 +++++++++++++++++
 tb/tb_inst_decode_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_pipe.sv
// Decode stage between fetch and execute.
// Fetched instructions queue in a small FIFO, sit in a single decode slot
// for LATENCY edges, then land in the output registers where the fields are
// split positionally. Both sides use valid/ready; flush empties everything
// but keeps the last presented fields on the output pins.
module inst_decode_pipe #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int LATENCY        = 2,
  parameter int DEPTH          = 4
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      inst_enable,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  input  logic                      distinct,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      distinct_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [5:0]                opcode,
  output logic [4:0]                rs,
  output logic [4:0]                rt,
  output logic [4:0]                rd,
  output logic [4:0]                sa,
  output logic [5:0]                funct,
  output logic [15:0]               immediate,
  output logic [25:0]               inst_index,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  // Entry layout: {distinct, pc1, pc, inst}
  localparam int ENTRY_W = 32 + 2 * INST_MEM_WIDTH + 1;
  localparam int PC_LSB  = 32;
  localparam int PC1_LSB = 32 + INST_MEM_WIDTH;
  localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;

  // Decode slot
  logic               slot_valid_reg;
  logic [3:0]         slot_cnt_reg;
  logic [ENTRY_W-1:0] slot_data_reg;

  // Output registers
  logic                      out_valid_reg;
  logic [31:0]               out_inst_reg;
  logic [INST_MEM_WIDTH-1:0] out_pc_reg;
  logic [INST_MEM_WIDTH-1:0] out_pc1_reg;
  logic                      out_distinct_reg;

  // Handshake / steering decisions for the coming edge
  logic               fifo_empty;
  logic               fifo_has_room;
  logic               out_free;
  logic               slot_complete;
  logic               slot_avail;
  logic               accept;
  logic               bypass;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] fifo_head;

  assign in_entry      = {distinct, pc1, pc, inst};
  assign fifo_head     = fifo_mem[rd_ptr_reg];
  assign fifo_empty    = (count_reg == '0);
  // A pop on a full edge does not open the door early: room is judged on
  // the registered occupancy only.
  assign fifo_has_room = (count_reg < CNT_W'(DEPTH));
  assign out_free      = !out_valid_reg || out_ready;
  assign slot_complete = slot_valid_reg && (slot_cnt_reg == 4'd0) && out_free;
  assign slot_avail    = !slot_valid_reg || slot_complete;
  // Flush drops a concurrent accept; nothing moves through the pipe.
  assign accept        = inst_enable && fifo_has_room && !flush;
  // An empty FIFO with a free slot lets the word skip the queue entirely.
  assign bypass        = accept && fifo_empty && slot_avail;
  assign push          = accept && !bypass;
  assign pop           = !flush && !fifo_empty && slot_avail;

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= in_entry;
  end

  // Decode slot: load from FIFO head or bypass, then count down to zero
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      slot_valid_reg <= 1'b0;
      slot_cnt_reg   <= 4'd0;
      slot_data_reg  <= '0;
    end else if (flush) begin
      slot_valid_reg <= 1'b0;
      slot_cnt_reg   <= 4'd0;
    end else if (pop) begin
      slot_valid_reg <= 1'b1;
      slot_cnt_reg   <= LOAD_CNT;
      slot_data_reg  <= fifo_head;
    end else if (bypass) begin
      slot_valid_reg <= 1'b1;
      slot_cnt_reg   <= LOAD_CNT;
      slot_data_reg  <= in_entry;
    end else if (slot_complete) begin
      slot_valid_reg <= 1'b0;
    end else if (slot_valid_reg && (slot_cnt_reg != 4'd0)) begin
      slot_cnt_reg   <= slot_cnt_reg - 4'd1;
    end
  end

  // Output registers: load on completion, drop valid after a transfer;
  // field contents are held (not cleared) while out_valid is low
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_valid_reg    <= 1'b0;
      out_inst_reg     <= '0;
      out_pc_reg       <= '0;
      out_pc1_reg      <= '0;
      out_distinct_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg    <= 1'b0;
    end else if (slot_complete) begin
      out_valid_reg    <= 1'b1;
      out_inst_reg     <= slot_data_reg[31:0];
      out_pc_reg       <= slot_data_reg[PC_LSB +: INST_MEM_WIDTH];
      out_pc1_reg      <= slot_data_reg[PC1_LSB +: INST_MEM_WIDTH];
      out_distinct_reg <= slot_data_reg[ENTRY_W-1];
    end else if (out_ready) begin
      out_valid_reg    <= 1'b0;
    end
  end

  // Positional field split; rd/sa/funct overlap immediate by design
  assign opcode        = out_inst_reg[31:26];
  assign rs            = out_inst_reg[25:21];
  assign rt            = out_inst_reg[20:16];
  assign rd            = out_inst_reg[15:11];
  assign sa            = out_inst_reg[10:6];
  assign funct         = out_inst_reg[5:0];
  assign immediate     = out_inst_reg[15:0];
  assign inst_index    = out_inst_reg[25:0];
  assign pc_next       = out_pc_reg;
  assign pc1_next      = out_pc1_reg;
  assign distinct_next = out_distinct_reg;
  assign out_valid     = out_valid_reg;
  assign in_ready      = fifo_has_room;
  assign count         = count_reg;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed bench for inst_decode_pipe. Three instances (LATENCY 2, 1, 4)
// share the same stimulus; most scenarios inspect the LATENCY=2 copy.
module tb_inst_decode_pipe;

  localparam int W  = 2;
  localparam int NI = 3;
  localparam logic [NI-1:0][3:0] LATS = {4'd4, 4'd1, 4'd2};

  logic        CLK = 1'b0;
  logic        reset;
  logic        flush;
  logic        inst_enable;
  logic        out_ready;
  logic [31:0] inst;
  logic        distinct;
  logic [W-1:0] pc;
  logic [W-1:0] pc1;

  logic [NI-1:0]        in_ready_w;
  logic [NI-1:0]        out_valid_w;
  logic [NI-1:0]        distinct_next_w;
  logic [NI-1:0][W-1:0] pc_next_w;
  logic [NI-1:0][W-1:0] pc1_next_w;
  logic [NI-1:0][5:0]   opcode_w;
  logic [NI-1:0][4:0]   rs_w;
  logic [NI-1:0][4:0]   rt_w;
  logic [NI-1:0][4:0]   rd_w;
  logic [NI-1:0][4:0]   sa_w;
  logic [NI-1:0][5:0]   funct_w;
  logic [NI-1:0][15:0]  immediate_w;
  logic [NI-1:0][25:0]  inst_index_w;
  logic [NI-1:0][2:0]   count_w;

  int checks = 0;
  int fails  = 0;
  int lat_tb [NI] = '{2, 1, 4};

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    inst_decode_pipe #(
      .INST_MEM_WIDTH(W),
      .LATENCY(int'(LATS[gi])),
      .DEPTH(4)
    ) u_dut (
      .CLK(CLK),
      .reset(reset),
      .flush(flush),
      .inst_enable(inst_enable),
      .in_ready(in_ready_w[gi]),
      .inst(inst),
      .distinct(distinct),
      .pc(pc),
      .pc1(pc1),
      .out_valid(out_valid_w[gi]),
      .out_ready(out_ready),
      .distinct_next(distinct_next_w[gi]),
      .pc_next(pc_next_w[gi]),
      .pc1_next(pc1_next_w[gi]),
      .opcode(opcode_w[gi]),
      .rs(rs_w[gi]),
      .rt(rt_w[gi]),
      .rd(rd_w[gi]),
      .sa(sa_w[gi]),
      .funct(funct_w[gi]),
      .immediate(immediate_w[gi]),
      .inst_index(inst_index_w[gi]),
      .count(count_w[gi])
    );
  end

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; flush = 1'b0; inst_enable = 1'b0; out_ready = 1'b0;
    inst = '0; distinct = 1'b0; pc = '0; pc1 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; inst_enable = 1'b0; out_ready = 1'b0;
    inst = '0; distinct = 1'b0; pc = '0; pc1 = '0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (out_valid_w[i] !== 1'b0) begin fails++; $display("FAIL reset_out_valid[%0d] got %0b expected 0", i, out_valid_w[i]); end
      checks++; if (in_ready_w[i] !== 1'b1) begin fails++; $display("FAIL reset_in_ready[%0d] got %0b expected 1", i, in_ready_w[i]); end
      checks++; if (count_w[i] !== 3'd0) begin fails++; $display("FAIL reset_count[%0d] got %0d expected 0", i, count_w[i]); end
    end
    checks++; if (inst_index_w[0] !== 26'd0 || opcode_w[0] !== 6'd0) begin fails++; $display("FAIL reset_fields got %h/%h expected 0/0", opcode_w[0], inst_index_w[0]); end
    checks++; if (pc_next_w[0] !== 2'd0 || pc1_next_w[0] !== 2'd0 || distinct_next_w[0] !== 1'b0) begin fails++; $display("FAIL reset_pc got %0d/%0d/%0b expected 0/0/0", pc_next_w[0], pc1_next_w[0], distinct_next_w[0]); end
    tick();
    reset = 1'b0;
    $display("reset done");
  endtask

  task automatic test_basic;
    do_reset();
    out_ready = 1'b1;
    inst = 32'h012A4020; pc = 2'd1; pc1 = 2'd2; distinct = 1'b1; inst_enable = 1'b1;
    tick();  // edge t
    inst_enable = 1'b0; inst = '0; pc = '0; pc1 = '0; distinct = 1'b0;
    checks++; if (out_valid_w[0] !== 1'b0) begin fails++; $display("FAIL basic_t_valid got %0b expected 0", out_valid_w[0]); end
    tick();  // t+1
    checks++; if (out_valid_w[0] !== 1'b0) begin fails++; $display("FAIL basic_t1_valid got %0b expected 0", out_valid_w[0]); end
    checks++; if (out_valid_w[1] !== 1'b1 || rd_w[1] !== 5'd8) begin fails++; $display("FAIL basic_lat1 got %0b/%0d expected 1/8", out_valid_w[1], rd_w[1]); end
    tick();  // t+2
    $display("basic out: valid=%0b op=%h rs=%0d rt=%0d rd=%0d fn=%h", out_valid_w[0], opcode_w[0], rs_w[0], rt_w[0], rd_w[0], funct_w[0]);
    checks++; if (out_valid_w[0] !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b expected 1", out_valid_w[0]); end
    checks++; if (opcode_w[0] !== 6'd0) begin fails++; $display("FAIL basic_opcode got %h expected 0", opcode_w[0]); end
    checks++; if (rs_w[0] !== 5'd9) begin fails++; $display("FAIL basic_rs got %0d expected 9", rs_w[0]); end
    checks++; if (rt_w[0] !== 5'd10) begin fails++; $display("FAIL basic_rt got %0d expected 10", rt_w[0]); end
    checks++; if (rd_w[0] !== 5'd8) begin fails++; $display("FAIL basic_rd got %0d expected 8", rd_w[0]); end
    checks++; if (sa_w[0] !== 5'd0) begin fails++; $display("FAIL basic_sa got %0d expected 0", sa_w[0]); end
    checks++; if (funct_w[0] !== 6'h20) begin fails++; $display("FAIL basic_funct got %h expected 20", funct_w[0]); end
    checks++; if (pc_next_w[0] !== 2'd1 || pc1_next_w[0] !== 2'd2) begin fails++; $display("FAIL basic_pc got %0d/%0d expected 1/2", pc_next_w[0], pc1_next_w[0]); end
    checks++; if (distinct_next_w[0] !== 1'b1) begin fails++; $display("FAIL basic_distinct got %0b expected 1", distinct_next_w[0]); end
  endtask

  task automatic test_back_to_back;
    int peak [NI];
    int exp_peak [NI] = '{1, 0, 2};
    int l;
    logic exp_v;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NI; i++) peak[i] = 0;
    for (int e = 0; e < 14; e++) begin
      if (e < 3) begin
        inst = 32'h0000_0100 + 32'(e); pc = 2'(e + 1); pc1 = 2'(e + 2); inst_enable = 1'b1;
      end else begin
        inst_enable = 1'b0;
      end
      tick();  // edge t+e
      for (int i = 0; i < NI; i++) begin
        l = lat_tb[i];
        exp_v = (e > 0) && (e % l == 0) && (e / l <= 3);
        if (int'(count_w[i]) > peak[i]) peak[i] = int'(count_w[i]);
        checks++; if (out_valid_w[i] !== exp_v) begin fails++; $display("FAIL b2b_valid lat=%0d edge=%0d got %0b expected %0b", l, e, out_valid_w[i], exp_v); end
        if (exp_v) begin
          $display("b2b lat=%0d edge=t+%0d imm=%h pc=%0d", l, e, immediate_w[i], pc_next_w[i]);
          checks++; if (immediate_w[i] !== 16'(16'h0100 + e / l - 1)) begin fails++; $display("FAIL b2b_order lat=%0d edge=%0d got %h expected %h", l, e, immediate_w[i], 16'(16'h0100 + e / l - 1)); end
          checks++; if (pc_next_w[i] !== 2'(e / l)) begin fails++; $display("FAIL b2b_pc lat=%0d edge=%0d got %0d expected %0d", l, e, pc_next_w[i], e / l); end
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      checks++; if (peak[i] != exp_peak[i]) begin fails++; $display("FAIL b2b_peak lat=%0d got %0d expected %0d", lat_tb[i], peak[i], exp_peak[i]); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (in_ready_w[0] !== 1'b1) begin fails++; $display("FAIL bp_in_ready_push%0d got %0b expected 1", k, in_ready_w[0]); end
      inst = 32'h0000_0200 + 32'(k); inst_enable = 1'b1;
      tick();
    end
    checks++; if (count_w[0] !== 3'd4) begin fails++; $display("FAIL bp_count_full got %0d expected 4", count_w[0]); end
    checks++; if (in_ready_w[0] !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full got %0b expected 0", in_ready_w[0]); end
    checks++; if (out_valid_w[0] !== 1'b1 || immediate_w[0] !== 16'h0200) begin fails++; $display("FAIL bp_presented got %0b/%h expected 1/0200", out_valid_w[0], immediate_w[0]); end
    inst = 32'h0000_0206; inst_enable = 1'b1;
    tick();
    checks++; if (count_w[0] !== 3'd4 || in_ready_w[0] !== 1'b0) begin fails++; $display("FAIL bp_refused got %0d/%0b expected 4/0", count_w[0], in_ready_w[0]); end
    checks++; if (immediate_w[0] !== 16'h0200) begin fails++; $display("FAIL bp_hold got %h expected 0200", immediate_w[0]); end
    $display("bp xfer imm=%h", immediate_w[0]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid_w[0] !== 1'b1 || immediate_w[0] !== 16'h0201) begin fails++; $display("FAIL bp_after_pulse got %0b/%h expected 1/0201", out_valid_w[0], immediate_w[0]); end
    checks++; if (count_w[0] !== 3'd3 || in_ready_w[0] !== 1'b1) begin fails++; $display("FAIL bp_pulse_count got %0d/%0b expected 3/1", count_w[0], in_ready_w[0]); end
    tick();
    inst_enable = 1'b0;
    checks++; if (count_w[0] !== 3'd4) begin fails++; $display("FAIL bp_sixth_accept got %0d expected 4", count_w[0]); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid_w[0]) begin
        $display("bp xfer imm=%h", immediate_w[0]);
        checks++; if (immediate_w[0] !== 16'(16'h0201 + n)) begin fails++; $display("FAIL bp_order got %h expected %h", immediate_w[0], 16'(16'h0201 + n)); end
        n++;
      end
      tick();
    end
    checks++; if (n != 6) begin fails++; $display("FAIL bp_drain_count got %0d expected 6", n); end
    out_ready = 1'b0;
  endtask

  task automatic test_lw;
    do_reset();
    out_ready = 1'b1;
    inst = 32'h8D0A0010; pc = 2'd3; pc1 = 2'd0; distinct = 1'b0; inst_enable = 1'b1;
    tick();
    inst_enable = 1'b0;
    tick();
    tick();
    $display("lw out: op=%h rs=%0d rt=%0d imm=%h idx=%h", opcode_w[0], rs_w[0], rt_w[0], immediate_w[0], inst_index_w[0]);
    checks++; if (out_valid_w[0] !== 1'b1) begin fails++; $display("FAIL lw_valid got %0b expected 1", out_valid_w[0]); end
    checks++; if (opcode_w[0] !== 6'h23) begin fails++; $display("FAIL lw_opcode got %h expected 23", opcode_w[0]); end
    checks++; if (rs_w[0] !== 5'd8 || rt_w[0] !== 5'd10) begin fails++; $display("FAIL lw_rs_rt got %0d/%0d expected 8/10", rs_w[0], rt_w[0]); end
    checks++; if (immediate_w[0] !== 16'h0010) begin fails++; $display("FAIL lw_imm got %h expected 0010", immediate_w[0]); end
    checks++; if (inst_index_w[0] !== 26'h10A0010) begin fails++; $display("FAIL lw_index got %h expected 10a0010", inst_index_w[0]); end
    checks++; if (funct_w[0] !== 6'h10 || rd_w[0] !== 5'd0) begin fails++; $display("FAIL lw_overlap got %h/%0d expected 10/0", funct_w[0], rd_w[0]); end
    tick();
    checks++; if (out_valid_w[0] !== 1'b0 || opcode_w[0] !== 6'h23) begin fails++; $display("FAIL lw_hold got %0b/%h expected 0/23", out_valid_w[0], opcode_w[0]); end
  endtask

  // Runs straight after test_lw so the LW fields are on the outputs.
  task automatic test_flush;
    out_ready = 1'b0;
    inst = 32'h0000_0301; inst_enable = 1'b1;
    tick();
    inst = 32'h0000_0302;
    tick();
    checks++; if (count_w[0] !== 3'd1) begin fails++; $display("FAIL flush_pre_count got %0d expected 1", count_w[0]); end
    inst = 32'h0000_0303; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; inst_enable = 1'b0;
    checks++; if (count_w[0] !== 3'd0 || in_ready_w[0] !== 1'b1) begin fails++; $display("FAIL flush_count got %0d/%0b expected 0/1", count_w[0], in_ready_w[0]); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid_w[0] !== 1'b0) begin fails++; $display("FAIL flush_valid cycle=%0d got %0b expected 0", c, out_valid_w[0]); end
      tick();
    end
    checks++; if (opcode_w[0] !== 6'h23 || immediate_w[0] !== 16'h0010) begin fails++; $display("FAIL flush_fields got %h/%h expected 23/0010", opcode_w[0], immediate_w[0]); end
    $display("flush done count=%0d", count_w[0]);
  endtask

  task automatic test_async_reset;
    do_reset();
    out_ready = 1'b0;
    inst = 32'h0000_0401; pc = 2'd1; inst_enable = 1'b1;
    tick();
    inst = 32'h0000_0402; pc = 2'd2;
    tick();
    inst_enable = 1'b0;
    tick();
    checks++; if (out_valid_w[0] !== 1'b1 || immediate_w[0] !== 16'h0401) begin fails++; $display("FAIL ar_pre got %0b/%h expected 1/0401", out_valid_w[0], immediate_w[0]); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid_w[0] !== 1'b0) begin fails++; $display("FAIL ar_valid got %0b expected 0", out_valid_w[0]); end
    checks++; if (immediate_w[0] !== 16'd0 || opcode_w[0] !== 6'd0 || pc_next_w[0] !== 2'd0) begin fails++; $display("FAIL ar_fields got %h/%h/%0d expected 0/0/0", immediate_w[0], opcode_w[0], pc_next_w[0]); end
    checks++; if (in_ready_w[0] !== 1'b1 || count_w[0] !== 3'd0) begin fails++; $display("FAIL ar_fifo got %0b/%0d expected 1/0", in_ready_w[0], count_w[0]); end
    tick();
    reset = 1'b0;
    inst = 32'h0000_0403; pc = 2'd3; inst_enable = 1'b1;
    tick();
    inst_enable = 1'b0;
    tick();
    checks++; if (out_valid_w[0] !== 1'b0) begin fails++; $display("FAIL ar_early got %0b expected 0", out_valid_w[0]); end
    tick();
    $display("ar out: imm=%h pc=%0d", immediate_w[0], pc_next_w[0]);
    checks++; if (out_valid_w[0] !== 1'b1 || immediate_w[0] !== 16'h0403 || pc_next_w[0] !== 2'd3) begin fails++; $display("FAIL ar_fresh got %0b/%h/%0d expected 1/0403/3", out_valid_w[0], immediate_w[0], pc_next_w[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_lw();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
